mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 51 +++++
 rtl/mem_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_arbiter.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Shared bus between the fetch port, the data port and the single-port RAM.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 8
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned MASK_W = 4;

    // Fetch port
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [DATA_W-1:0] i_rdata;

    // Data port
    logic              d_req;
    logic              d_we;
    logic [MASK_W-1:0] d_wmask;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    // RAM side
    logic              mem_en;
    logic [MASK_W-1:0] mem_wmask;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter view
    modport slave (
        input  i_req, i_addr,
        output i_gnt, i_rvalid, i_rdata,
        input  d_req, d_we, d_wmask, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_wmask, mem_addr, mem_wdata,
        input  mem_rdata
    );

    // Requester / RAM-model view
    modport master (
        output i_req, i_addr,
        input  i_gnt, i_rvalid, i_rdata,
        output d_req, d_we, d_wmask, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_wmask, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one synchronous single-port RAM between a
// fetch port and a data port, with saturating performance counters.
module mem_arbiter #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned CNT_W  = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    mem_arbiter_if.slave     bus,
    output logic [CNT_W-1:0] cnt_i,
    output logic [CNT_W-1:0] cnt_d,
    output logic [CNT_W-1:0] cnt_conf
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned MASK_W = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    owner_e              tag_q, tag_d;
    logic                last_d_q, last_d_d;
    logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic [CNT_W-1:0]    cnt_i_q, cnt_i_d;
    logic [CNT_W-1:0]    cnt_d_q, cnt_d_d;
    logic [CNT_W-1:0]    cnt_conf_q, cnt_conf_d;

    logic                i_gnt_c, d_gnt_c;
    logic                i_rvalid_c, d_rvalid_c;
    logic [DATA_W-1:0]   i_rdata_c, d_rdata_c;
    logic                mem_en_c;
    logic [MASK_W-1:0]   mem_wmask_c;
    logic [ADDR_W-1:0]   mem_addr_c;
    logic [DATA_W-1:0]   mem_wdata_c;

    // Grant decision and RAM command; data wins a conflict unless it was served last
    always_comb begin
        i_gnt_c     = 1'b0;
        d_gnt_c     = 1'b0;
        mem_addr_c  = bus.i_addr;
        mem_wmask_c = '0;
        mem_wdata_c = '0;
        if (!RESET) begin
            if (bus.d_req && (!bus.i_req || !last_d_q)) begin
                d_gnt_c = 1'b1;
            end else if (bus.i_req) begin
                i_gnt_c = 1'b1;
            end
        end
        if (d_gnt_c) begin
            mem_addr_c = bus.d_addr;
            if (bus.d_we) begin
                mem_wmask_c = bus.d_wmask;
                mem_wdata_c = bus.d_wdata;
            end
        end
        mem_en_c = i_gnt_c | d_gnt_c;
    end

    // Read return: the owner tag steers RAM data to the port that issued the read
    always_comb begin
        i_rvalid_c = (tag_q == OWN_I) && !RESET;
        d_rvalid_c = (tag_q == OWN_D) && !RESET;
        i_rdata_c  = i_rvalid_c ? bus.mem_rdata : i_rdata_q;
        d_rdata_c  = d_rvalid_c ? bus.mem_rdata : d_rdata_q;
    end

    // Next-state: owner tag, round-robin pointer, held read data, saturating counters
    always_comb begin
        tag_d      = OWN_NONE;
        last_d_d   = last_d_q;
        i_rdata_d  = i_rdata_c;
        d_rdata_d  = d_rdata_c;
        cnt_i_d    = cnt_i_q;
        cnt_d_d    = cnt_d_q;
        cnt_conf_d = cnt_conf_q;
        if (i_gnt_c) begin
            tag_d    = OWN_I;
            last_d_d = 1'b0;
        end else if (d_gnt_c) begin
            last_d_d = 1'b1;
            if (!bus.d_we) begin
                tag_d = OWN_D;
            end
        end
        if (i_gnt_c && (cnt_i_q != '1)) begin
            cnt_i_d = cnt_i_q + CNT_W'(1);
        end
        if (d_gnt_c && (cnt_d_q != '1)) begin
            cnt_d_d = cnt_d_q + CNT_W'(1);
        end
        if (bus.i_req && bus.d_req && (cnt_conf_q != '1)) begin
            cnt_conf_d = cnt_conf_q + CNT_W'(1);
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RESET) begin
            tag_q      <= OWN_NONE;
            last_d_q   <= 1'b0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
            cnt_i_q    <= '0;
            cnt_d_q    <= '0;
            cnt_conf_q <= '0;
        end else begin
            tag_q      <= tag_d;
            last_d_q   <= last_d_d;
            i_rdata_q  <= i_rdata_d;
            d_rdata_q  <= d_rdata_d;
            cnt_i_q    <= cnt_i_d;
            cnt_d_q    <= cnt_d_d;
            cnt_conf_q <= cnt_conf_d;
        end
    end

    assign bus.i_gnt     = i_gnt_c;
    assign bus.d_gnt     = d_gnt_c;
    assign bus.i_rvalid  = i_rvalid_c;
    assign bus.d_rvalid  = d_rvalid_c;
    assign bus.i_rdata   = i_rdata_c;
    assign bus.d_rdata   = d_rdata_c;
    assign bus.mem_en    = mem_en_c;
    assign bus.mem_wmask = mem_wmask_c;
    assign bus.mem_addr  = mem_addr_c;
    assign bus.mem_wdata = mem_wdata_c;
    assign cnt_i         = cnt_i_q;
    assign cnt_d         = cnt_d_q;
    assign cnt_conf      = cnt_conf_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch/data arbitration, RAM writes with
// byte masks, reset behaviour and counter saturation.
module tb_mem_arbiter;
    logic        clk;
    logic        rst;
    logic [31:0] cnt_i, cnt_d, cnt_conf;
    logic [3:0]  s_cnt_i, s_cnt_d, s_cnt_conf;
    int          n_checks;
    int          n_fail;
    logic [31:0] ram [256];
    logic [31:0] pre_val [4];
    logic [3:0]  exp_d_gnt;

    mem_arbiter_if #(.ADDR_W(8)) bus ();
    mem_arbiter_if #(.ADDR_W(8)) s_bus ();

    mem_arbiter #(.ADDR_W(8), .CNT_W(32)) dut (
        .CLK      (clk),
        .RESET    (rst),
        .bus      (bus),
        .cnt_i    (cnt_i),
        .cnt_d    (cnt_d),
        .cnt_conf (cnt_conf)
    );

    mem_arbiter #(.ADDR_W(8), .CNT_W(4)) dut_sat (
        .CLK      (clk),
        .RESET    (rst),
        .bus      (s_bus),
        .cnt_i    (s_cnt_i),
        .cnt_d    (s_cnt_d),
        .cnt_conf (s_cnt_conf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port RAM model: read-before-write, byte-lane writes
    always @(posedge clk) begin
        if (bus.mem_en) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.mem_wmask[b]) ram[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
            end
            bus.mem_rdata <= ram[bus.mem_addr];
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.i_req   = 1'b0;
        bus.i_addr  = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_wmask = '0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic d_wr(input logic [7:0] a, input logic [31:0] v, input logic [3:0] m);
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = a;
        bus.d_wdata = v;
        bus.d_wmask = m;
        tick();
        idle();
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        pre_val[0] = 32'h1234_5678;
        pre_val[1] = 32'h9ABC_DEF0;
        pre_val[2] = 32'h0F0F_0F0F;
        pre_val[3] = 32'hCAFE_F00D;
        exp_d_gnt  = 4'b0101;
        s_bus.i_req = 1'b0; s_bus.i_addr = '0; s_bus.d_req = 1'b0; s_bus.d_we = 1'b0;
        s_bus.d_wmask = '0; s_bus.d_addr = '0; s_bus.d_wdata = '0; s_bus.mem_rdata = '0;
        bus.mem_rdata = '0;

        // Reset forces grants and RAM strobes low even with both requesting
        rst = 1'b1;
        idle();
        bus.i_req = 1'b1; bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_wmask = 4'hF;
        tick();
        tick();
        check_eq("rst_i_gnt", bus.i_gnt, 0);
        check_eq("rst_d_gnt", bus.d_gnt, 0);
        check_eq("rst_mem_en", bus.mem_en, 0);
        check_eq("rst_mem_wmask", bus.mem_wmask, 0);
        check_eq("rst_i_rvalid", bus.i_rvalid, 0);
        check_eq("rst_d_rvalid", bus.d_rvalid, 0);
        check_eq("rst_i_rdata", bus.i_rdata, 0);
        check_eq("rst_d_rdata", bus.d_rdata, 0);
        check_eq("rst_cnt_i", cnt_i, 0);
        check_eq("rst_cnt_d", cnt_d, 0);
        check_eq("rst_cnt_conf", cnt_conf, 0);
        idle();
        rst = 1'b0;

        // Preload RAM through the data port
        for (int a = 0; a < 4; a++) d_wr(8'(a), pre_val[a], 4'hF);
        d_wr(8'd5, 32'h0010_0093, 4'hF);
        d_wr(8'd7, 32'hDEAD_BEEF, 4'hF);

        // Fetch-only read of address 5
        do_reset();
        bus.i_req = 1'b1; bus.i_addr = 8'd5;
        #1;
        check_eq("f_i_gnt", bus.i_gnt, 1);
        check_eq("f_d_gnt", bus.d_gnt, 0);
        check_eq("f_mem_en", bus.mem_en, 1);
        check_eq("f_mem_addr", bus.mem_addr, 5);
        check_eq("f_mem_wmask", bus.mem_wmask, 0);
        check_eq("f_mem_wdata", bus.mem_wdata, 0);
        tick();
        idle();
        #1;
        check_eq("f_i_rvalid", bus.i_rvalid, 1);
        check_eq("f_i_rdata", bus.i_rdata, 32'h0010_0093);
        check_eq("f_cnt_i", cnt_i, 1);
        check_eq("f_idle_mem_en", bus.mem_en, 0);
        tick();
        check_eq("f_i_rvalid_drop", bus.i_rvalid, 0);
        check_eq("f_i_rdata_hold", bus.i_rdata, 32'h0010_0093);

        // Conflict after reset: D,I,D,I
        do_reset();
        for (int k = 0; k < 4; k++) begin
            bus.i_req = 1'b1; bus.i_addr = 8'd5;
            bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 8'd7;
            #1;
            check_eq($sformatf("c_d_gnt%0d", k), bus.d_gnt, exp_d_gnt[k]);
            check_eq($sformatf("c_i_gnt%0d", k), bus.i_gnt, !exp_d_gnt[k]);
            if (k > 0) begin
                check_eq($sformatf("c_d_rvalid%0d", k), bus.d_rvalid, exp_d_gnt[k-1]);
                check_eq($sformatf("c_i_rvalid%0d", k), bus.i_rvalid, !exp_d_gnt[k-1]);
            end
            if (k == 1 || k == 3) check_eq($sformatf("c_d_rdata%0d", k), bus.d_rdata, 32'hDEAD_BEEF);
            if (k == 2) check_eq("c_i_rdata2", bus.i_rdata, 32'h0010_0093);
            tick();
        end
        idle();
        #1;
        check_eq("c_i_rvalid4", bus.i_rvalid, 1);
        check_eq("c_i_rdata4", bus.i_rdata, 32'h0010_0093);
        check_eq("c_d_rvalid4", bus.d_rvalid, 0);
        check_eq("c_d_rdata_hold", bus.d_rdata, 32'hDEAD_BEEF);
        check_eq("c_cnt_conf", cnt_conf, 4);
        check_eq("c_cnt_i", cnt_i, 2);
        check_eq("c_cnt_d", cnt_d, 2);
        tick();

        // Back-to-back fetches of addresses 0..3
        for (int a = 0; a < 4; a++) begin
            bus.i_req = 1'b1; bus.i_addr = 8'(a);
            #1;
            check_eq($sformatf("b_i_gnt%0d", a), bus.i_gnt, 1);
            if (a > 0) begin
                check_eq($sformatf("b_i_rvalid%0d", a), bus.i_rvalid, 1);
                check_eq($sformatf("b_i_rdata%0d", a), bus.i_rdata, pre_val[a-1]);
            end
            tick();
        end
        idle();
        #1;
        check_eq("b_i_rvalid4", bus.i_rvalid, 1);
        check_eq("b_i_rdata4", bus.i_rdata, pre_val[3]);
        tick();
        check_eq("b_i_rvalid_end", bus.i_rvalid, 0);

        // Masked write, zero-mask write, then data read-back
        d_wr(8'd3, 32'h0, 4'hF);
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 8'd3;
        bus.d_wdata = 32'hAABB_CCDD; bus.d_wmask = 4'b0101;
        #1;
        check_eq("w_d_gnt", bus.d_gnt, 1);
        check_eq("w_mem_addr", bus.mem_addr, 3);
        check_eq("w_mem_wmask", bus.mem_wmask, 4'b0101);
        check_eq("w_mem_wdata", bus.mem_wdata, 32'hAABB_CCDD);
        tick();
        idle();
        #1;
        check_eq("w_no_d_rvalid", bus.d_rvalid, 0);
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 8'd3;
        bus.d_wdata = 32'hFFFF_FFFF; bus.d_wmask = 4'b0000;
        #1;
        check_eq("z_d_gnt", bus.d_gnt, 1);
        check_eq("z_mem_en", bus.mem_en, 1);
        check_eq("z_mem_wmask", bus.mem_wmask, 0);
        tick();
        idle();
        #1;
        check_eq("z_no_d_rvalid", bus.d_rvalid, 0);
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 8'd3; bus.d_wdata = 32'hFFFF_FFFF;
        #1;
        check_eq("r_mem_wdata", bus.mem_wdata, 0);
        tick();
        idle();
        #1;
        check_eq("r_d_rvalid", bus.d_rvalid, 1);
        check_eq("r_d_rdata", bus.d_rdata, 32'h00BB_00DD);
        tick();
        check_eq("r_d_rvalid_drop", bus.d_rvalid, 0);
        check_eq("r_d_rdata_hold", bus.d_rdata, 32'h00BB_00DD);

        // Reset in the cycle after a data-read grant drops the read
        do_reset();
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 8'd7;
        #1;
        check_eq("m_d_gnt", bus.d_gnt, 1);
        tick();
        idle();
        rst = 1'b1;
        #1;
        check_eq("m_d_rvalid_in_rst", bus.d_rvalid, 0);
        tick();
        check_eq("m_d_rvalid", bus.d_rvalid, 0);
        check_eq("m_d_rdata", bus.d_rdata, 0);
        check_eq("m_cnt_d", cnt_d, 0);
        check_eq("m_cnt_i", cnt_i, 0);
        check_eq("m_cnt_conf", cnt_conf, 0);
        rst = 1'b0;
        tick();
        check_eq("m_d_rvalid_after", bus.d_rvalid, 0);

        // Saturation of a 4-bit counter
        do_reset();
        s_bus.i_req = 1'b1;
        repeat (10) tick();
        check_eq("s_cnt_i10", s_cnt_i, 10);
        repeat (10) tick();
        check_eq("s_cnt_i20", s_cnt_i, 15);
        check_eq("s_i_gnt", s_bus.i_gnt, 1);
        check_eq("s_cnt_d", s_cnt_d, 0);
        check_eq("s_cnt_conf", s_cnt_conf, 0);
        s_bus.i_req = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
